// File: rtl/inst_fetch_queue.sv
// Fetch stage behind the PC register: issues in-order imem reads and pairs each PC with its returned word for decode.
// Optional misaligned-fetch exception entries are enabled by defining FETCH_ADEF_CHECK_EN.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        pc_enable,
    input  logic        flush,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_adef
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      entPc_q     [DEPTH];
    logic [31:0]      entPc_d     [DEPTH];
    logic [31:0]      entInst_q   [DEPTH];
    logic [31:0]      entInst_d   [DEPTH];
    logic             entFilled_q [DEPTH];
    logic             entFilled_d [DEPTH];
    logic             entAdef_q   [DEPTH];
    logic             entAdef_d   [DEPTH];

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] fillPtr_q, fillPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] dropCnt_q, dropCnt_d;

    logic             misaligned;
    logic             canIssue;
    logic             reqFire;
    logic             adefFire;
    logic             allocEn;
    logic             popEn;
    logic [PTR_W-1:0] fillIdx;

`ifdef FETCH_ADEF_CHECK_EN
    // Exception entries are born filled, so a response belongs to the oldest allocated entry still waiting.
    always_comb begin
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] age;
        logic             found;
        fillIdx = fillPtr_q;
        found   = 1'b0;
        idx     = '0;
        age     = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = fillPtr_q + PTR_W'(i);
            age = idx - rdPtr_q;
            if (!found && ({1'b0, age} < count_q) && !entFilled_q[idx]) begin
                fillIdx = idx;
                found   = 1'b1;
            end
        end
    end
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign fillIdx    = fillPtr_q;
    assign misaligned = 1'b0;
`endif

    // Slots still owed a stale response keep their credit until it drains.
    assign canIssue       = !rst && !flush &&
                            (({1'b0, count_q} + {1'b0, dropCnt_q}) < SUM_W'(DEPTH));
    assign imem_req_valid = canIssue && !misaligned;
    assign adefFire       = canIssue && misaligned;
    assign reqFire        = imem_req_valid && imem_req_ready;
    assign allocEn        = reqFire || adefFire;
    assign pc_enable      = allocEn;
    assign imem_addr      = pc;

    assign id_valid = (count_q != '0) && entFilled_q[rdPtr_q];
    assign id_pc    = entPc_q[rdPtr_q];
    assign id_inst  = entInst_q[rdPtr_q];
    assign id_adef  = entAdef_q[rdPtr_q];
    assign popEn    = id_valid && id_ready;

    always_comb begin
        entPc_d       = entPc_q;
        entInst_d     = entInst_q;
        entFilled_d   = entFilled_q;
        entAdef_d     = entAdef_q;
        wrPtr_d       = wrPtr_q;
        fillPtr_d     = fillPtr_q;
        rdPtr_d       = rdPtr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q - CNT_W'(imem_rsp_valid);
        dropCnt_d     = dropCnt_q;
        if (flush) begin
            wrPtr_d   = '0;
            fillPtr_d = '0;
            rdPtr_d   = '0;
            count_d   = '0;
            dropCnt_d = outstanding_q - CNT_W'(imem_rsp_valid);
            for (int i = 0; i < int'(DEPTH); i++) begin
                entFilled_d[i] = 1'b0;
            end
        end else begin
            if (allocEn) begin
                entPc_d[wrPtr_q]     = pc;
                entInst_d[wrPtr_q]   = '0;
                entFilled_d[wrPtr_q] = adefFire;
                entAdef_d[wrPtr_q]   = adefFire;
                wrPtr_d              = wrPtr_q + PTR_W'(1);
            end
            if (imem_rsp_valid) begin
                if (dropCnt_q != '0) begin
                    dropCnt_d = dropCnt_q - CNT_W'(1);
                end else begin
                    entInst_d[fillIdx]   = imem_rsp_data;
                    entFilled_d[fillIdx] = 1'b1;
                    fillPtr_d            = fillIdx + PTR_W'(1);
                end
            end
            if (popEn) begin
                entFilled_d[rdPtr_q] = 1'b0;
                rdPtr_d              = rdPtr_q + PTR_W'(1);
            end
            count_d       = count_q + CNT_W'(allocEn) - CNT_W'(popEn);
            outstanding_d = outstanding_q + CNT_W'(reqFire) - CNT_W'(imem_rsp_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entPc_q       <= '{default: '0};
            entInst_q     <= '{default: '0};
            entFilled_q   <= '{default: 1'b0};
            entAdef_q     <= '{default: 1'b0};
            wrPtr_q       <= '0;
            fillPtr_q     <= '0;
            rdPtr_q       <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            dropCnt_q     <= '0;
        end else begin
            entPc_q       <= entPc_d;
            entInst_q     <= entInst_d;
            entFilled_q   <= entFilled_d;
            entAdef_q     <= entAdef_d;
            wrPtr_q       <= wrPtr_d;
            fillPtr_q     <= fillPtr_d;
            rdPtr_q       <= rdPtr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            dropCnt_q     <= dropCnt_d;
        end
    end

    // The PC register must reset to a word-aligned address, and queued plus stale slots never exceed DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (RESET_PC[1:0] == 2'b00);
            assert (({1'b0, count_q} + {1'b0, dropCnt_q}) <= SUM_W'(DEPTH));
        end
    end
endmodule
